// File: rtl/prim_packer_arb.sv
// prim_packer_arb: round-robin arbiter and flush sequencer that lets NumReq
// requesters share one bit-packer. One requester owns the packer at a time;
// its beats pass straight through, and when its packet ends a one-cycle
// flush is issued and the arbiter waits for flush_done before re-arbitrating.
// Optional build macro: PRIM_PACKER_ARB_MAX_BEATS_EN (caps beats per grant).
module prim_packer_arb #(
  parameter int NumReq   = 4,
  parameter int InW      = 32,
  parameter int MaxBeats = 16,
  localparam int IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq*InW-1:0] req_data_i,
  input  logic [NumReq*InW-1:0] req_mask_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic                  pk_valid_o,
  output logic [InW-1:0]        pk_data_o,
  output logic [InW-1:0]        pk_mask_o,
  input  logic                  pk_ready_i,
  output logic                  pk_flush_o,
  input  logic                  pk_flush_done_i,
  output logic [IdxW-1:0]       owner_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Grant    = 2'd1,
    Flush    = 2'd2,
    WaitDone = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_q, rr_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] scan;

  logic            own_valid;
  logic            own_last;
  logic [InW-1:0]  own_data;
  logic [InW-1:0]  own_mask;
  logic            accept;
  logic            force_flush;

  // Select the owner's request signals with an explicit compare mux so that
  // non-power-of-two NumReq never indexes past the end of the buses.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    own_mask  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (owner_q == IdxW'(k)) begin
        own_valid = req_valid_i[k];
        own_last  = req_last_i[k];
        own_data  = req_data_i[k*InW +: InW];
        own_mask  = req_mask_i[k*InW +: InW];
      end
    end
  end

  assign accept = (state_q == Grant) & own_valid & pk_ready_i;

  // Round-robin pick: scan rr_q, rr_q+1, ... with explicit wrap at NumReq-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = rr_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!pick_found && req_valid_i[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
      scan = (scan == IdxW'(NumReq - 1)) ? '0 : scan + IdxW'(1);
    end
  end

`ifdef PRIM_PACKER_ARB_MAX_BEATS_EN
  localparam int CntW = $clog2(MaxBeats + 1);
  logic [CntW-1:0] beat_q;

  // Beats accepted in the current grant; cleared on entry to Grant, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else if (state_q == Idle && pick_found) begin
      beat_q <= '0;
    end else if (accept && beat_q != CntW'(MaxBeats)) begin
      beat_q <= beat_q + CntW'(1);
    end
  end

  assign force_flush = (beat_q == CntW'(MaxBeats - 1));
`else
  logic unused_cfg;
  assign unused_cfg  = ^MaxBeats;
  assign force_flush = 1'b0;
`endif

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      Idle: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = Grant;
        end
      end
      Grant: begin
        if (accept && (own_last || force_flush)) state_d = Flush;
      end
      Flush: state_d = WaitDone;
      WaitDone: begin
        if (pk_flush_done_i) begin
          rr_d    = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Output logic: beats pass through only in Grant, data gated when not valid.
  always_comb begin
    req_ready_o = '0;
    pk_valid_o  = 1'b0;
    pk_data_o   = '0;
    pk_mask_o   = '0;
    pk_flush_o  = 1'b0;
    unique case (state_q)
      Grant: begin
        pk_valid_o = own_valid;
        pk_data_o  = own_valid ? own_data : '0;
        pk_mask_o  = own_valid ? own_mask : '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
          if (owner_q == IdxW'(k)) req_ready_o[k] = pk_ready_i;
        end
      end
      Flush:   pk_flush_o = 1'b1;
      default: ;
    endcase
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != Idle);

endmodule

// File: tb/tb_prim_packer_arb.sv
// Directed self-checking bench for prim_packer_arb (NumReq=4, InW=32).
module tb_prim_packer_arb;

  localparam int NumReq = 4;
  localparam int InW    = 32;
`ifdef PRIM_PACKER_ARB_MAX_BEATS_EN
  localparam int MaxB   = 4;
`else
  localparam int MaxB   = 16;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NumReq-1:0]     req_valid_i;
  logic [NumReq*InW-1:0] req_data_i;
  logic [NumReq*InW-1:0] req_mask_i;
  logic [NumReq-1:0]     req_last_i;
  logic [NumReq-1:0]     req_ready_o;
  logic                  pk_valid_o;
  logic [InW-1:0]        pk_data_o;
  logic [InW-1:0]        pk_mask_o;
  logic                  pk_ready_i;
  logic                  pk_flush_o;
  logic                  pk_flush_done_i;
  logic [1:0]            owner_o;
  logic                  busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  prim_packer_arb #(.NumReq(NumReq), .InW(InW), .MaxBeats(MaxB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_mask_i(req_mask_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .pk_valid_o(pk_valid_o), .pk_data_o(pk_data_o), .pk_mask_o(pk_mask_o),
    .pk_ready_i(pk_ready_i), .pk_flush_o(pk_flush_o),
    .pk_flush_done_i(pk_flush_done_i),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] d, input logic [31:0] m,
                         input logic v, input logic l);
    req_data_i[k*InW +: InW] = d;
    req_mask_i[k*InW +: InW] = m;
    req_valid_i[k] = v;
    req_last_i[k]  = l;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid_i = '0; req_data_i = '0; req_mask_i = '0; req_last_i = '0;
    pk_ready_i = 1'b0; pk_flush_done_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int flush_cnt;
    logic [1:0] exp_order [6];
    exp_order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    // ---- reset state and 20 idle cycles ----
    do_reset();
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_valid", pk_valid_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_data", pk_data_o, 0);
    flush_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      if (pk_flush_o || busy_o || pk_valid_o || req_ready_o != 0 || pk_mask_o != 0) flush_cnt++;
    end
    chk("idle_quiet_cycles", flush_cnt, 0);

    // ---- req 2 sends 3 beats ----
    do_reset();
    pk_ready_i = 1'b1;
    set_req(2, 32'h1111_0000, 32'h0000_00FF, 1'b1, 1'b0);
    #1;
    chk("idle_no_ready", req_ready_o, 0);
    chk("idle_no_valid", pk_valid_o, 0);
    @(negedge clk_i); #1;
    chk("p1_owner", owner_o, 2);
    chk("p1_busy", busy_o, 1);
    chk("p1_b0_valid", pk_valid_o, 1);
    chk("p1_b0_data", pk_data_o, 32'h1111_0000);
    chk("p1_b0_mask", pk_mask_o, 32'h0000_00FF);
    chk("p1_b0_ready", req_ready_o, 4'b0100);
    @(negedge clk_i);
    set_req(2, 32'h1111_0001, 32'h0000_00FF, 1'b1, 1'b0);
    #1;
    chk("p1_b1_data", pk_data_o, 32'h1111_0001);
    chk("p1_b1_flush", pk_flush_o, 0);
    @(negedge clk_i);
    set_req(2, 32'h1111_0002, 32'h0000_00FF, 1'b1, 1'b1);
    #1;
    chk("p1_b2_data", pk_data_o, 32'h1111_0002);
    @(negedge clk_i);
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("p1_flush", pk_flush_o, 1);
    chk("p1_flush_novalid", pk_valid_o, 0);
    chk("p1_flush_noready", req_ready_o, 0);
    @(negedge clk_i);
    pk_flush_done_i = 1'b1;
    #1;
    chk("p1_wait_flush", pk_flush_o, 0);
    chk("p1_wait_busy", busy_o, 1);
    @(negedge clk_i);
    pk_flush_done_i = 1'b0;
    #1;
    chk("p1_idle_busy", busy_o, 0);

    // ---- reqs 0,1,3 continuous single-beat packets ----
    do_reset();
    pk_ready_i = 1'b1;
    pk_flush_done_i = 1'b1;
    set_req(0, 32'hC0, '1, 1'b1, 1'b1);
    set_req(1, 32'hC1, '1, 1'b1, 1'b1);
    set_req(3, 32'hC3, '1, 1'b1, 1'b1);
    g = 0;
    flush_cnt = 0;
    for (int i = 0; i < 40 && g < 6; i++) begin
      @(negedge clk_i); #1;
      if (pk_valid_o && pk_flush_o) flush_cnt++;
      if (pk_valid_o && pk_ready_i) begin
        chk("rr_order", owner_o, exp_order[g]);
        chk("rr_data", pk_data_o, 32'hC0 + 32'(exp_order[g]));
        g++;
      end
    end
    chk("rr_grant_count", g, 6);
    chk("rr_valid_during_flush", flush_cnt, 0);

    // ---- stall mid-packet, then delayed flush_done ----
    do_reset();
    pk_ready_i = 1'b1;
    set_req(1, 32'hAAAA_0001, 32'h0000_FFFF, 1'b1, 1'b0);
    @(negedge clk_i); #1;
    chk("st_owner", owner_o, 1);
    chk("st_b0_data", pk_data_o, 32'hAAAA_0001);
    @(negedge clk_i);
    set_req(1, 32'hAAAA_0002, 32'h0000_FFFF, 1'b1, 1'b0);
    pk_ready_i = 1'b0;
    flush_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (req_ready_o != 0 || pk_data_o != 32'hAAAA_0002 || !pk_valid_o ||
          !busy_o || owner_o != 2'd1 || pk_flush_o) flush_cnt++;
      @(negedge clk_i);
    end
    chk("st_hold_errors", flush_cnt, 0);
    pk_ready_i = 1'b1;
    set_req(1, 32'hAAAA_0002, 32'h0000_FFFF, 1'b1, 1'b1);
    #1;
    chk("st_resume_ready", req_ready_o, 4'b0010);
    chk("st_resume_data", pk_data_o, 32'hAAAA_0002);
    @(negedge clk_i);
    set_req(1, 32'h0, 32'h0, 1'b0, 1'b0);
    set_req(0, 32'hBBBB_0000, 32'h0000_000F, 1'b1, 1'b1);
    #1;
    chk("dd_flush", pk_flush_o, 1);
    chk("dd_flush_novalid", pk_valid_o, 0);
    flush_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); #1;
      if (pk_flush_o || !busy_o || pk_valid_o || req_ready_o != 0) flush_cnt++;
    end
    chk("dd_wait_errors", flush_cnt, 0);
    @(negedge clk_i);
    pk_flush_done_i = 1'b1;
    #1;
    chk("dd_done_busy", busy_o, 1);
    @(negedge clk_i);
    pk_flush_done_i = 1'b0;
    #1;
    chk("dd_idle", busy_o, 0);
    chk("dd_idle_ready", req_ready_o, 0);
    @(negedge clk_i); #1;
    chk("dd_next_owner", owner_o, 0);
    chk("dd_next_data", pk_data_o, 32'hBBBB_0000);
    chk("dd_next_ready", req_ready_o, 4'b0001);

`ifdef PRIM_PACKER_ARB_MAX_BEATS_EN
    // ---- forced preemption after MaxBeats=4 ----
    do_reset();
    pk_ready_i = 1'b1;
    pk_flush_done_i = 1'b1;
    set_req(1, 32'hD000_0000, '1, 1'b1, 1'b0);
    set_req(2, 32'hE000_0000, '1, 1'b1, 1'b1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_i);
      set_req(1, 32'hD000_0000 + 32'(b), '1, 1'b1, 1'b0);
      #1;
      chk("mb_owner1", owner_o, 1);
      chk("mb_data", pk_data_o, 32'hD000_0000 + 32'(b));
    end
    @(negedge clk_i);
    set_req(1, 32'hD000_0004, '1, 1'b1, 1'b0);
    #1;
    chk("mb_forced_flush", pk_flush_o, 1);
    @(negedge clk_i); // WaitDone
    @(negedge clk_i); // Idle
    @(negedge clk_i); #1;
    chk("mb_owner2", owner_o, 2);
    chk("mb_data2", pk_data_o, 32'hE000_0000);
    @(negedge clk_i);
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i); // WaitDone
    @(negedge clk_i); // Idle
    @(negedge clk_i); #1;
    chk("mb_resume_owner", owner_o, 1);
    chk("mb_resume_data", pk_data_o, 32'hD000_0004);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
